// File: rtl/shift_unit_iter.sv
// rtl/shift_unit_iter.sv - iterative SLL/SRL/SRA shifter, STEP bits per cycle, valid/ready on both sides.
// Optional SHIFT_UNIT_ROTATE_EN: mode 11 rotates left; otherwise mode 11 acts as SLL.
module shift_unit_iter #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic [1:0]        mode_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;
   // One extra bit so STEP == DATA_W still fits in the comparison.
   localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W+1)'(STEP);

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0]  rem_q, rem_d;
   logic [1:0]          mode_q, mode_d;

   logic [SHAMT_W:0]    rem_ext;
   logic [SHAMT_W:0]    k;
   logic [DATA_W-1:0]   shifted;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         work_q  <= '0;
         rem_q   <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      rem_ext = {1'b0, rem_q};
      k       = (rem_ext < STEP_C) ? rem_ext : STEP_C;
   end

   // Per-step shifter only spans amounts 1..STEP, so it stays a small mux of constant shifts.
   always_comb begin
      shifted = work_q;
      for (int i = 1; i <= STEP; i++) begin
         if (k == (SHAMT_W+1)'(i)) begin
            case (mode_q)
               MODE_SLL: shifted = work_q << i;
               MODE_SRL: shifted = work_q >> i;
               MODE_SRA: shifted = DATA_W'($signed(work_q) >>> i);
`ifdef SHIFT_UNIT_ROTATE_EN
               default:  shifted = (work_q << i) | (work_q >> (DATA_W - i));
`else
               default:  shifted = work_q << i;
`endif
            endcase
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (valid_i) state_d = (shamt_i == '0) ? DONE : SHIFT;
         SHIFT:   if (rem_ext <= STEP_C) state_d = DONE;
         DONE:    if (ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      work_d = work_q;
      rem_d  = rem_q;
      mode_d = mode_q;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               work_d = data_i;
               rem_d  = shamt_i;
               mode_d = mode_i;
            end
         end
         SHIFT: begin
            work_d = shifted;
            rem_d  = rem_q - k[SHAMT_W-1:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      ready_o = (state_q == IDLE) && rst_i;
      valid_o = (state_q == DONE);
      busy_o  = (state_q == SHIFT) || (state_q == DONE);
      data_o  = work_q;
   end

endmodule

// File: doc/shift_unit_iter.md
Name: shift_unit_iter

Overview:
- Parametrised, multi-cycle successor to the fixed 32-bit shift-left-by-two block.
- Performs a variable-amount logical left, logical right or arithmetic right shift on a DATA_W-bit operand, STEP bit positions per clock.
- Uses valid/ready handshakes on input and output.
- Sits beside the EX-stage ALU. It serves shift instructions (sll/srl/sra/sllv/srlv/srav) where a single-cycle full barrel shifter is too costly in area.

Parameters:
- DATA_W, 32: operand/result width; power of two, >= 8.
- SHAMT_W, 5: shift-amount width; equals log2(DATA_W).
- STEP, 4: bit positions shifted per SHIFT cycle; power of two, 1..DATA_W.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- valid_i  input  1  request valid.
- ready_o  output  1  unit can accept a request (high only in IDLE).
- data_i  input  DATA_W  operand.
- shamt_i  input  SHAMT_W  shift amount, 0..DATA_W-1.
- mode_i  input  2  00 SLL, 01 SRL, 10 SRA, 11 see Optional Feature.
- valid_o  output  1  result valid (high only in DONE).
- ready_i  input  1  consumer accepts result.
- data_o  output  DATA_W  result; equals internal working register.
- busy_o  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_i low, asynchronous, effective immediately, any state):
  - state returns to IDLE; working register, remaining count and latched mode all clear to 0.
  - data_o=0, valid_o=0, busy_o=0.
  - ready_o=1 only once rst_i is high.
  - An in-flight operation is discarded, with no partial result.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready_o=1.
  - On a rising edge with valid_i=1: latch data_i into the working register, mode_i into the mode register, and shamt_i into rem.
  - Next state is DONE if shamt_i==0, else SHIFT.
- SHIFT:
  - Each edge: k = min(STEP, rem); shift the working register by k according to the latched mode; rem <= rem-k.
  - When rem <= STEP on that edge, next state is DONE.
  - valid_i is ignored.
- Shift rules per step:
  - SLL: zero fill at the LSBs.
  - SRL: zero fill at the MSBs.
  - SRA: fill with the working register's MSB. The MSB is preserved, so the final result equals a single-shot arithmetic shift.
- DONE:
  - valid_o=1; data_o held stable while ready_i=0.
  - On an edge with ready_i=1, go to IDLE.
  - No request is accepted in the same cycle as result release; ready_o stays 0 in DONE.
- Latency, measured from the accept edge to valid_o rising: ceil(shamt/STEP) cycles. shamt=0 gives valid_o in the cycle immediately after acceptance.
- Throughput: one operation per (latency + 2) cycles minimum.
- Final result is identical to a combinational shift of data_i by shamt_i for all modes and amounts.
- Changes on data_i, shamt_i or mode_i after acceptance have no effect.
- data_o outside DONE reflects intermediate values and is don't-care to consumers.

Optional Feature:
- Macro: SHIFT_UNIT_ROTATE_EN.
- Defined: mode 11 = rotate left; bits shifted out of the MSB re-enter at the LSB each step.
- Undefined: mode 11 behaves exactly as SLL.
- All other modes are unchanged either way.

Test Plan:
1. SLL: data_i=0x00000001, shamt=2, STEP=4 -> valid_o one cycle after accept, data_o=0x00000004.
2. SRA: data_i=0x80000000, shamt=31 -> data_o=0xFFFFFFFF, valid_o after 8 cycles, busy_o high throughout.
3. SRL: data_i=0x80000000, shamt=31 -> data_o=0x00000001; repeat with STEP=1 -> 31-cycle latency, same value.
4. Backpressure, shamt=0:
   - data_i=0x12345678, shamt=0 -> valid_o next cycle with data 0x12345678.
   - Hold ready_i=0 for 3 cycles -> data_o/valid_o stable, ready_o=0, a concurrent valid_i with 0xFFFFFFFF is ignored.
   - ready_i=1 -> IDLE, ready_o=1.
5. Reset mid-SHIFT: drop rst_i during the 3rd SHIFT cycle of a shamt=20 op -> data_o=0, valid_o=0, busy_o=0 immediately; after release, a fresh SLL 0x1 by 1 returns 0x00000002.
6. Mode 11: data_i=0x80000001, shamt=4 -> data_o=0x00000018 with SHIFT_UNIT_ROTATE_EN defined, 0x00000010 without.
